// File: rtl/sr_sched_pkg.sv
// Shared op codes and FSM state encoding for the SR flip-flop command scheduler.
package sr_sched_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_NOP = 2'b00;
    localparam op_t OP_SET = 2'b01;
    localparam op_t OP_RST = 2'b10;
    localparam op_t OP_TGL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Small power-of-two command FIFO: synchronous push/pop, async active-high reset, registered head.
module sr_cmd_fifo
    import sr_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  op_t  din,
    input  logic pop,
    output logic full,
    output logic empty,
    output op_t  head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    op_t            mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap modulo DEPTH by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sr_cmd_scheduler.sv
// Queues SET/RESET/TOGGLE commands and drives one-hot S/R pulses, checking Q after each pulse.
// Optional saturating mismatch counter err_cnt enabled by defining SR_SCHED_ERRCNT_EN.
module sr_cmd_scheduler
    import sr_sched_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PULSE_CYC = 1,
    parameter int unsigned GAP_CYC   = 1
`ifdef SR_SCHED_ERRCNT_EN
    ,parameter int unsigned CNT_W    = 8
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    output logic             req_ready,
    input  logic             q_fb,
    output logic             S,
    output logic             R,
    output logic             busy,
    output logic             err
`ifdef SR_SCHED_ERRCNT_EN
    ,output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int unsigned PH_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;

    state_t          state;
    state_t          state_nx;
    logic [PH_W-1:0] ph_cnt;
    logic [PH_W-1:0] ph_nx;
    logic            exp_q;
    logic            exp_nx;
    logic            s_nx;
    logic            r_nx;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    op_t             fifo_head;

    // NOPs complete the handshake but never occupy a slot.
    assign req_ready = !fifo_full && !RST;
    assign fifo_push = req_valid && req_ready && (op_t'(req_op) != OP_NOP);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    sr_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (fifo_push),
        .din   (op_t'(req_op)),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            ph_cnt <= '0;
            exp_q  <= 1'b0;
            S      <= 1'b0;
            R      <= 1'b0;
        end else begin
            state  <= state_nx;
            ph_cnt <= ph_nx;
            exp_q  <= exp_nx;
            S      <= s_nx;
            R      <= r_nx;
        end
    end

    // Next-state, next S/R and the CHECK-cycle mismatch flag; S/R derive from a single exp bit.
    always_comb begin
        state_nx = state;
        ph_nx    = ph_cnt;
        exp_nx   = exp_q;
        fifo_pop = 1'b0;
        s_nx     = 1'b0;
        r_nx     = 1'b0;
        err      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_nx = ST_DRIVE;
                    ph_nx    = PH_W'(PULSE_CYC - 1);
                    case (fifo_head)
                        OP_RST:  exp_nx = 1'b0;
                        OP_TGL:  exp_nx = !q_fb;
                        default: exp_nx = 1'b1;
                    endcase
                    s_nx = exp_nx;
                    r_nx = !exp_nx;
                end
            end
            ST_DRIVE: begin
                if (ph_cnt == '0) begin
                    state_nx = ST_GAP;
                    ph_nx    = PH_W'(GAP_CYC - 1);
                end else begin
                    ph_nx = ph_cnt - PH_W'(1);
                    s_nx  = exp_q;
                    r_nx  = !exp_q;
                end
            end
            ST_GAP: begin
                if (ph_cnt == '0) state_nx = ST_CHECK;
                else              ph_nx    = ph_cnt - PH_W'(1);
            end
            ST_CHECK: begin
                err      = (q_fb != exp_q);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef SR_SCHED_ERRCNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                       err_cnt <= '0;
        else if (err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
`endif

endmodule
